shared_ram_arbiter: RTL and testbench
=====================================

Name: shared_ram_arbiter

Overview:
Two-requester arbiter that shares one single-port synchronous RAM between the main and sub CPU buses of an arcade core, such as the shared work RAM of the two-6809 boards.
Each CPU presents a level request. The block grants one requester at a time, sequences the RAM access, and returns a one-cycle ack plus registered read data.
It also drives per-port wait signals that the CPU clock-enable logic uses to stretch the bus cycle. This is the glue that replaces the discrete TTL bus-multiplexing and arbitration logic.

Parameters:
AW, 11, address width
DW, 8, data width
RAM_LAT, 1, synchronous RAM read latency in clocks; legal 1..3
PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
clk_49m  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
req0  in  1  port 0 request (level); held with addr/we/wdata stable until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
rdata0  out  DW  port 0 read data, registered
ack0  out  1  port 0 completion pulse, one cycle
wait0  out  1  port 0 stall = req0 & ~ack0
req1, we1, addr1, wdata1, rdata1, ack1, wait1  same for port 1
ram_addr  out  AW  RAM address, registered
ram_wdata  out  DW  RAM write data, registered
ram_we  out  1  RAM write strobe, registered
ram_rdata  in  DW  RAM read data, valid RAM_LAT clocks after ram_addr

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - FSM to IDLE; round-robin pointer "last granted" = port 1;
  - rdata0/1, ack0/1, ram_addr, ram_wdata, ram_we all to 0.
  - Any in-flight access is dropped: no ack, and ram_we deasserts immediately.
- FSM states: IDLE, ISSUE, RDWAIT, ACK.
- IDLE: sample req0/req1 at each edge.
  - None set: stay in IDLE.
  - One set: grant that port.
  - Both set, PRIO_FIXED=0: grant the port that is not "last granted".
  - Both set, PRIO_FIXED=1: grant port 0.
  - On any grant: register addr/wdata/we of the granted port into ram_addr/ram_wdata/ram_we, store the grant index, go to ISSUE.
- ISSUE (one cycle): RAM sees the address, and ram_we if this is a write.
  - Write: next state ACK; ram_we cleared on leaving ISSUE, so ram_we is high exactly one cycle.
  - Read: next state RDWAIT, with a counter loaded to RAM_LAT-1.
- RDWAIT: decrement the counter.
  - When the counter is 0, capture ram_rdata into rdata of the granted port, go to ACK.
- ACK (one cycle): ack of the granted port = 1; update "last granted"; go to IDLE.
- Timing, with the request accepted at edge N:
  - Write: ram_we high during cycle N+1; ack during cycle N+2.
  - Read: ack during cycle N+2+RAM_LAT; rdata valid from the same cycle.
- There is one mandatory IDLE cycle after every ACK.
  - A req still high in that IDLE cycle is treated as a new request (back-to-back access).
  - Requesters must drop req in the ACK cycle for single accesses.
- The ungranted port keeps wait=1 for the whole transaction; its request stays pending and is served next.
- rdata of a port holds its value until that port's next read ack; writes never change rdata.
- If req drops mid-transaction (protocol violation), the access still completes to RAM and ack still pulses.
- ram_addr/ram_wdata hold their last value between transactions; ram_we is only ever high in ISSUE.
- Round-robin fairness: with both ports continuously requesting, grants strictly alternate. With PRIO_FIXED=1, port 1 may starve; this is allowed.

Decomposition:
- Package shared_ram_pkg:
  - state enum (IDLE, ISSUE, RDWAIT, ACK);
  - port-index typedef (1 bit);
  - default AW/DW constants.
- Sub-module shram_rr_pick: combinational two-way pick.
  - Inputs: req0, req1, last, fixed.
  - Outputs: valid, idx.
- Top module holds the FSM, latency counter, registers and wait logic.

Test Plan:
- Reset: hold reset=0 with random req inputs -> all outputs 0, wait0=req0, wait1=req1, no ram_we; release -> first tie grants port 0.
- Port 0 write of 0xA5 to addr 0x123 accepted at edge N -> ram_we=1 only in cycle N+1 with ram_addr=0x123, ram_wdata=0xA5; ack0 in N+2; wait0 low from N+2.
- Port 1 read of 0x123, RAM_LAT=1 (RAM model returns the written data) -> ack1 in N+3 with rdata1=0xA5; rdata0 unchanged.
- RAM_LAT=3, port 0 read -> ack0 exactly in N+5; no ack earlier.
- Both ports hold req continuously for 6 accesses (PRIO_FIXED=0) -> grant order 0,1,0,1,0,1. With PRIO_FIXED=1 -> 0,0,0,0,0,0, and wait1 held high throughout.
- Assert reset in the RDWAIT cycle of a RAM_LAT=3 read -> ack never pulses, ram_we=0; after release, a held req is re-accepted and completes normally.

Source files
------------

// File: rtl/shared_ram_arbiter_pkg.sv
// Shared types and defaults for the two-CPU shared RAM arbiter.
// Imported by the arbiter top and its pick helper.
package shared_ram_pkg;

   localparam int AW_DEF = 11;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

   typedef logic port_idx_t;

   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/shared_ram_arbiter_pick.sv
// Combinational two-way requester pick: round-robin on "last granted",
// or port 0 always wins a tie when fixed priority is selected.
module shram_rr_pick
   import shared_ram_pkg::*;
(
   input  logic      req0,
   input  logic      req1,
   input  port_idx_t last,
   input  logic      fixed,
   output logic      valid,
   output port_idx_t idx
);

   // NOTE: every output is assigned on every path, so no latch is inferred.
   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         idx = fixed ? PORT0 : port_idx_t'(~last);
      end else begin
         idx = req1 ? PORT1 : PORT0;
      end
   end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Shares one single-port synchronous RAM between the main and sub CPU buses:
// grants one requester at a time, sequences the access, returns ack and data.
module shared_ram_arbiter
   import shared_ram_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int RAM_LAT    = 1,
   parameter int PRIO_FIXED = 0
) (
   input  logic          clk_49m,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic [DW-1:0] rdata0,
   output logic          ack0,
   output logic          wait0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic [DW-1:0] rdata1,
   output logic          ack1,
   output logic          wait1,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);
   localparam logic       FIXED    = (PRIO_FIXED != 0);

   state_t        state_q;
   port_idx_t     last_q;
   port_idx_t     grant_q;
   logic [1:0]    cnt_q;
   logic [DW-1:0] rdata0_q, rdata1_q;
   logic          ack0_q, ack1_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_wdata_q;
   logic          ram_we_q;

   logic      pick_valid;
   port_idx_t pick_idx;

   shram_rr_pick u_pick (
      .req0  (req0),
      .req1  (req1),
      .last  (last_q),
      .fixed (FIXED),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= PORT1;
         grant_q     <= PORT0;
         cnt_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
      end else begin
         // NOTE: acks default low every clock, so setting one on ACK entry yields a single-cycle pulse.
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q     <= pick_idx;
                  ram_addr_q  <= (pick_idx == PORT1) ? addr1  : addr0;
                  ram_wdata_q <= (pick_idx == PORT1) ? wdata1 : wdata0;
                  ram_we_q    <= (pick_idx == PORT1) ? we1    : we0;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               ram_we_q <= 1'b0;
               if (ram_we_q) begin
                  ack0_q  <= (grant_q == PORT0);
                  ack1_q  <= (grant_q == PORT1);
                  state_q <= ACK;
               end else begin
                  cnt_q   <= LAT_LOAD;
                  state_q <= RDWAIT;
               end
            end
            RDWAIT: begin
               if (cnt_q == 2'd0) begin
                  if (grant_q == PORT1) rdata1_q <= ram_rdata;
                  else                  rdata0_q <= ram_rdata;
                  ack0_q  <= (grant_q == PORT0);
                  ack1_q  <= (grant_q == PORT1);
                  state_q <= ACK;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            ACK: begin
               last_q  <= grant_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign wait0     = req0 & ~ack0_q;
   assign wait1     = req1 & ~ack1_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter: instance 0 is RAM_LAT=1 round-robin,
// instance 1 is RAM_LAT=3 fixed priority; each has its own RAM model.
module tb_shared_ram_arbiter;

   localparam int AW = 11;
   localparam int DW = 8;

   logic          clk_49m = 1'b0;
   logic          reset   = 1'b0;
   logic          req0 [2], we0 [2], req1 [2], we1 [2];
   logic [AW-1:0] addr0 [2], addr1 [2];
   logic [DW-1:0] wdata0 [2], wdata1 [2];
   logic [DW-1:0] rdata0 [2], rdata1 [2];
   logic          ack0 [2], ack1 [2], wait0 [2], wait1 [2];
   logic [AW-1:0] ram_addr [2];
   logic [DW-1:0] ram_wdata [2], ram_rdata [2];
   logic          ram_we [2];

   int errors = 0;
   int checks = 0;

   always #10 clk_49m = ~clk_49m;

   shared_ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(1), .PRIO_FIXED(0)) dut_rr (
      .clk_49m(clk_49m), .reset(reset),
      .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
      .rdata0(rdata0[0]), .ack0(ack0[0]), .wait0(wait0[0]),
      .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
      .rdata1(rdata1[0]), .ack1(ack1[0]), .wait1(wait1[0]),
      .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]),
      .ram_rdata(ram_rdata[0])
   );

   shared_ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(3), .PRIO_FIXED(1)) dut_fx (
      .clk_49m(clk_49m), .reset(reset),
      .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
      .rdata0(rdata0[1]), .ack0(ack0[1]), .wait0(wait0[1]),
      .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
      .rdata1(rdata1[1]), .ack1(ack1[1]), .wait1(wait1[1]),
      .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]),
      .ram_rdata(ram_rdata[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_ram
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [DW-1:0] mem [0:(1<<AW)-1];
      logic [DW-1:0] pipe [0:2];
      always @(posedge clk_49m) begin
         if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
         pipe[0] <= mem[ram_addr[g]];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign ram_rdata[g] = pipe[LAT-1];
   end

   function automatic logic get_ack(input int d, input bit p);
      return p ? ack1[d] : ack0[d];
   endfunction

   function automatic logic get_wait(input int d, input bit p);
      return p ? wait1[d] : wait0[d];
   endfunction

   function automatic logic [DW-1:0] get_rdata(input int d, input bit p);
      return p ? rdata1[d] : rdata0[d];
   endfunction

   task automatic set_req(input int d, input bit p, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (p) begin
         req1[d] = 1'b1; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
      end else begin
         req0[d] = 1'b1; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
      end
   endtask

   task automatic drop_req(input int d, input bit p);
      if (p) req1[d] = 1'b0;
      else   req0[d] = 1'b0;
   endtask

   // Single access from the IDLE cycle; k counts cycles after the accepting edge.
   task automatic xfer(input int d, input bit p, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int exp_k,
                       input logic [DW-1:0] exp_rd, input string nm);
      bit seen = 0;
      set_req(d, p, w, a, wd);
      for (int k = 1; k <= 10 && !seen; k++) begin
         @(negedge clk_49m);
         if (k == 1) begin
            checks++;
            if (ram_addr[d] !== a) begin
               errors++;
               $display("FAIL %s ram_addr: got %h want %h", nm, ram_addr[d], a);
            end
            if (w) begin
               checks++;
               if (ram_wdata[d] !== wd) begin
                  errors++;
                  $display("FAIL %s ram_wdata: got %h want %h", nm, ram_wdata[d], wd);
               end
            end
         end
         checks++;
         if (ram_we[d] !== (w && k == 1)) begin
            errors++;
            $display("FAIL %s ram_we cycle N+%0d: got %b want %b", nm, k, ram_we[d], w && k == 1);
         end
         checks++;
         if (get_wait(d, p) !== (k != exp_k)) begin
            errors++;
            $display("FAIL %s wait cycle N+%0d: got %b want %b", nm, k, get_wait(d, p), k != exp_k);
         end
         if (get_ack(d, p) === 1'b1) begin
            seen = 1;
            checks++;
            if (k != exp_k) begin
               errors++;
               $display("FAIL %s ack cycle: got N+%0d want N+%0d", nm, k, exp_k);
            end
            if (!w) begin
               checks++;
               if (get_rdata(d, p) !== exp_rd) begin
                  errors++;
                  $display("FAIL %s rdata: got %h want %h", nm, get_rdata(d, p), exp_rd);
               end
            end
            drop_req(d, p);
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s ack timeout: got none want N+%0d", nm, exp_k);
         drop_req(d, p);
      end
      @(negedge clk_49m);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         for (int d = 0; d < 2; d++) begin
            req0[d] = 1'($urandom_range(1)); req1[d] = 1'($urandom_range(1));
         end
         #7;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ack0[d], ack1[d], ram_we[d], rdata0[d], rdata1[d], ram_addr[d], ram_wdata[d]} !== '0) begin
               errors++;
               $display("FAIL reset_outputs dut%0d: got ack=%b%b we=%b rd=%h/%h addr=%h wd=%h want all 0",
                        d, ack0[d], ack1[d], ram_we[d], rdata0[d], rdata1[d], ram_addr[d], ram_wdata[d]);
            end
            checks++;
            if (wait0[d] !== req0[d] || wait1[d] !== req1[d]) begin
               errors++;
               $display("FAIL reset_wait dut%0d: got %b%b want %b%b", d, wait0[d], wait1[d], req0[d], req1[d]);
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         req0[d] = 1'b0; req1[d] = 1'b0;
      end
      @(negedge clk_49m);
      reset = 1'b1;
   endtask

   // Both ports request continuously; record the order of the first six grants.
   task automatic test_arb(input int d, input bit fixed_exp, input string nm);
      int  n = 0;
      bit  w1_low = 0;
      logic exp_g;
      set_req(d, 0, 1'b1, 11'h200, 8'h11);
      set_req(d, 1, 1'b1, 11'h300, 8'h22);
      for (int k = 0; k < 40 && n < 6; k++) begin
         @(negedge clk_49m);
         if (wait1[d] !== 1'b1) w1_low = 1;
         if (ack0[d] === 1'b1 || ack1[d] === 1'b1) begin
            exp_g = fixed_exp ? 1'b0 : 1'(n % 2);
            checks++;
            if (ack1[d] !== exp_g || ack0[d] !== ~exp_g) begin
               errors++;
               $display("FAIL %s grant %0d: got ack0=%b ack1=%b want port %0d", nm, n, ack0[d], ack1[d], exp_g);
            end
            n++;
            if (n == 6) begin
               drop_req(d, 0);
               drop_req(d, 1);
            end
         end
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL %s grant count: got %0d want 6", nm, n);
         drop_req(d, 0);
         drop_req(d, 1);
      end
      if (fixed_exp) begin
         checks++;
         if (w1_low) begin
            errors++;
            $display("FAIL %s wait1 held: got low at some cycle want 1 throughout", nm);
         end
      end
      @(negedge clk_49m);
   endtask

   task automatic test_write_read();
      xfer(0, 0, 1'b1, 11'h123, 8'hA5, 2, 8'h00, "p0_write");
      checks++;
      if (rdata0[0] !== 8'h00) begin
         errors++;
         $display("FAIL write_keeps_rdata0: got %h want 00", rdata0[0]);
      end
      xfer(0, 0, 1'b0, 11'h200, 8'h00, 3, 8'h11, "p0_read");
      xfer(0, 1, 1'b0, 11'h123, 8'h00, 3, 8'hA5, "p1_read");
      checks++;
      if (rdata0[0] !== 8'h11) begin
         errors++;
         $display("FAIL rdata0_hold: got %h want 11", rdata0[0]);
      end
   endtask

   task automatic test_lat3();
      xfer(1, 0, 1'b1, 11'h045, 8'h5C, 2, 8'h00, "lat3_write");
      xfer(1, 0, 1'b0, 11'h045, 8'h00, 5, 8'h5C, "lat3_read");
   endtask

   task automatic test_back_to_back();
      int first = 0, second = 0;
      set_req(0, 0, 1'b0, 11'h300, 8'h00);
      for (int k = 1; k <= 14 && second == 0; k++) begin
         @(negedge clk_49m);
         if (ack0[0] === 1'b1) begin
            if (first == 0) first = k;
            else begin
               second = k;
               drop_req(0, 0);
            end
         end
      end
      if (second == 0) drop_req(0, 0);
      checks++;
      if (first != 3 || second != 7) begin
         errors++;
         $display("FAIL b2b ack cycles: got N+%0d,N+%0d want N+3,N+7", first, second);
      end
      checks++;
      if (rdata0[0] !== 8'h22) begin
         errors++;
         $display("FAIL b2b rdata0: got %h want 22", rdata0[0]);
      end
      @(negedge clk_49m);
   endtask

   task automatic test_reset_midflight();
      bit acked = 0;
      set_req(1, 0, 1'b0, 11'h045, 8'h00);
      @(negedge clk_49m);
      @(negedge clk_49m);
      reset = 1'b0;
      #1;
      checks++;
      if (ack0[1] !== 1'b0 || ram_we[1] !== 1'b0 || rdata0[1] !== 8'h00 || wait0[1] !== 1'b1) begin
         errors++;
         $display("FAIL midflight_reset: got ack0=%b we=%b rdata0=%h wait0=%b want 0 0 00 1",
                  ack0[1], ram_we[1], rdata0[1], wait0[1]);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_49m);
         if (ack0[1] !== 1'b0 || ram_we[1] !== 1'b0) acked = 1;
      end
      checks++;
      if (acked) begin
         errors++;
         $display("FAIL midflight_no_ack: got ack or ram_we during reset want none");
      end
      reset = 1'b1;
      xfer(1, 0, 1'b0, 11'h045, 8'h00, 5, 8'h5C, "reaccept");
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req0[d] = 1'b0; we0[d] = 1'b0; addr0[d] = '0; wdata0[d] = '0;
         req1[d] = 1'b0; we1[d] = 1'b0; addr1[d] = '0; wdata1[d] = '0;
      end
      test_reset();
      test_arb(0, 1'b0, "rr_arb");
      test_arb(1, 1'b1, "fixed_arb");
      test_write_read();
      test_lat3();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
